// File: rtl/full_adder_pkg.sv
// Shared constants for the registered three-operand adder.
// res_w gives the full result width for a given operand width.
package full_adder_pkg;

  localparam int WIDTH_DEF = 2;

  // a + b + Cin never exceeds 3*(2^w-1), which always fits in w+2 bits.
  function automatic int res_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// One-bit combinational full adder cell.
// Used for both the carry-save row and the ripple row of full_adder.
module fa_bit (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ z;
  assign co = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/full_adder.sv
// Registered three-operand unsigned adder: {carry,sum} = a + b + Cin.
// A carry-save row of fa_bit cells reduces the three operands, and a ripple row then resolves them.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] Cin,
  output logic [WIDTH:0]   sum,
  output logic             carry
);

  localparam int RW = res_w(WIDTH);

  logic [WIDTH-1:0] ps;
  logic [WIDTH-1:0] pc;
  logic [WIDTH:0]   rx;
  logic [WIDTH:0]   ry;
  logic [WIDTH:0]   rs;
  logic [WIDTH+1:0] rc;
  logic [RW-1:0]    res_d;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_csa
      fa_bit u_csa (
        .x  (a[i]),
        .y  (b[i]),
        .z  (Cin[i]),
        .s  (ps[i]),
        .co (pc[i])
      );
    end
  endgenerate

  // Ripple row adds the partial sums to the carries shifted up one place.
  // It is one bit wider than the operands, so the top carry lands in rc[WIDTH+1].
  assign rx    = {1'b0, ps};
  assign ry    = {pc, 1'b0};
  assign rc[0] = 1'b0;

  generate
    for (i = 0; i <= WIDTH; i++) begin : g_rip
      fa_bit u_rip (
        .x  (rx[i]),
        .y  (ry[i]),
        .z  (rc[i]),
        .s  (rs[i]),
        .co (rc[i+1])
      );
    end
  endgenerate

  assign res_d = {rc[WIDTH+1], rs};

  always_ff @(posedge clk) begin
    if (rst) begin
      {carry, sum} <= '0;
    end else begin
      {carry, sum} <= res_d;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Scoreboard bench for full_adder at WIDTH=2 (directed and exhaustive) and WIDTH=4 (random).
// The driver queues the expected results; a monitor on the falling edge pops them and compares.
module tb_full_adder;
  import full_adder_pkg::*;

  localparam int RW2 = res_w(2);
  localparam int RW4 = res_w(4);

  logic       clk;
  logic       rst;
  logic [1:0] a2, b2, c2;
  logic [2:0] sum2;
  logic       carry2;
  logic [3:0] a4, b4, c4;
  logic [4:0] sum4;
  logic       carry4;

  logic [RW2-1:0] q2[$];
  logic [RW4-1:0] q4[$];

  int compared   = 0;
  int mismatched = 0;

  full_adder #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst   (rst),
    .a     (a2),
    .b     (b2),
    .Cin   (c2),
    .sum   (sum2),
    .carry (carry2)
  );

  full_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .a     (a4),
    .b     (b4),
    .Cin   (c4),
    .sum   (sum4),
    .carry (carry4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus and queue the expected results once the edge has taken it.
  task automatic drive(input logic r, input int va, input int vb, input int vc);
    int ra, rb, rcin;
    @(negedge clk);
    ra   = $urandom_range(15);
    rb   = $urandom_range(15);
    rcin = $urandom_range(15);
    rst  = r;
    a2   = va[1:0];
    b2   = vb[1:0];
    c2   = vc[1:0];
    a4   = ra[3:0];
    b4   = rb[3:0];
    c4   = rcin[3:0];
    @(posedge clk);
    if (r) begin
      q2.push_back('0);
      q4.push_back('0);
    end else begin
      q2.push_back(RW2'(va + vb + vc));
      q4.push_back(RW4'(ra + rb + rcin));
    end
  endtask

  always @(negedge clk) begin
    logic [RW2-1:0] e2;
    logic [RW4-1:0] e4;
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      compared++;
      if ({carry2, sum2} !== e2) begin
        mismatched++;
        $display("FAIL w2_result at %0t: got {carry,sum}=%b required %b", $time, {carry2, sum2}, e2);
      end
    end
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      compared++;
      if ({carry4, sum4} !== e4) begin
        mismatched++;
        $display("FAIL w4_result at %0t: got {carry,sum}=%b required %b", $time, {carry4, sum4}, e4);
      end
    end
  end

  initial begin
    rst = 1'b1;
    a2 = '0; b2 = '0; c2 = '0;
    a4 = '0; b4 = '0; c4 = '0;

    // Reset holds outputs at zero even with full-scale operands present.
    drive(1'b1, 3, 3, 3);
    drive(1'b1, 3, 3, 3);

    drive(1'b0, 0, 3, 2);
    drive(1'b0, 1, 3, 2);
    drive(1'b0, 1, 2, 2);
    drive(1'b0, 3, 3, 3);
    drive(1'b0, 0, 0, 0);

    // Reset arriving right after a full-scale operand overrides the result at that edge.
    drive(1'b0, 3, 3, 3);
    drive(1'b1, 2, 1, 3);
    drive(1'b0, 2, 1, 3);

    for (int va = 0; va < 4; va++)
      for (int vb = 0; vb < 4; vb++)
        for (int vc = 0; vc < 4; vc++)
          drive(1'b0, va, vb, vc);

    for (int n = 0; n < 200; n++)
      drive(($urandom_range(19) == 0), $urandom_range(3), $urandom_range(3), $urandom_range(3));

    for (int n = 0; n < 5 && (q2.size() > 0 || q4.size() > 0); n++)
      @(posedge clk);
    #1;
    if (q2.size() > 0 || q4.size() > 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d results still pending, required 0/0", q2.size(), q4.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
